// File: rtl/motor_pkg.sv
// Shared motor-control ADC definitions: MCP3008 frame geometry, reader FSM states
// and the raw-code to accelerator scaling used by every ADC reader instance.
package motor_pkg;

  localparam int unsigned ADC_BITS               = 10;
  localparam int unsigned MCP3008_FRAME_CLKS     = 17;
  localparam int unsigned MCP3008_FIRST_DATA_CLK = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } adc_state_t;

  // 32-bit intermediate keeps (raw - low_th) * gain from wrapping for any sane gain.
  function automatic logic [ADC_BITS-1:0] accel_scale(
    input logic [ADC_BITS-1:0] raw,
    input int unsigned         low_th,
    input int unsigned         high_th,
    input int unsigned         gain,
    input int unsigned         accel_max
  );
    int unsigned         r;
    int unsigned         prod;
    logic [ADC_BITS-1:0] res;
    r = 32'(raw);
    if (r < low_th) begin
      res = '0;
    end else if (r > high_th) begin
      res = ADC_BITS'(accel_max);
    end else begin
      prod = (r - low_th) * gain;
      res  = (prod > accel_max) ? ADC_BITS'(accel_max) : ADC_BITS'(prod);
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// SCLK phase timer: counts CLK_DIV cycles per half-period and strobes on the last
// cycle of each phase. Held at the start of a low phase while disabled or cleared.
module spi_phase_timer #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic rise_o,
  output logic fall_o,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            phase_hi_d, phase_hi_q;
  logic            end_phase;

  always_comb begin
    end_phase  = en_i && (cnt_q == CntMax);
    tick_o     = end_phase;
    rise_o     = end_phase && !phase_hi_q;
    fall_o     = end_phase && phase_hi_q;
    cnt_d      = cnt_q + 1'b1;
    phase_hi_d = phase_hi_q;
    if (!en_i || clr_i) begin
      cnt_d      = '0;
      phase_hi_d = 1'b0;
    end else if (end_phase) begin
      cnt_d      = '0;
      phase_hi_d = ~phase_hi_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      phase_hi_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_hi_q <= phase_hi_d;
    end
  end

endmodule

// File: rtl/mcp3008_accel_reader.sv
// MCP3008 SPI master (mode 0,0): runs one 17-clock conversion frame per accepted start
// and registers the raw code together with its saturated accelerator scaling.
module mcp3008_accel_reader
  import motor_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned LOW_TH    = 280,
  parameter int unsigned HIGH_TH   = 780,
  parameter int unsigned GAIN      = 2,
  parameter int unsigned ACCEL_MAX = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          channel,
  input  logic                sgl_diff,
  output logic                busy,
  output logic                sample_valid,
  output logic [ADC_BITS-1:0] sample,
  output logic [ADC_BITS-1:0] accel,
  output logic                sclk,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam logic [4:0] FirstDataClk = 5'(MCP3008_FIRST_DATA_CLK);
  localparam logic [4:0] LastClk      = 5'(MCP3008_FRAME_CLKS);

  adc_state_t          state_d, state_q;
  logic [2:0]          ch_d, ch_q;
  logic                sgl_d, sgl_q;
  logic [4:0]          bit_cnt_d, bit_cnt_q;
  logic [ADC_BITS-1:0] shift_d, shift_q;
  logic [ADC_BITS-1:0] sample_d, sample_q;
  logic [ADC_BITS-1:0] accel_d, accel_q;
  logic                valid_d, valid_q;
  logic                busy_d, busy_q;
  logic                sclk_d, sclk_q;
  logic                cs_n_d, cs_n_q;
  logic                mosi_d, mosi_q;
  logic                tmr_en, tmr_clr, tmr_rise, tmr_fall, tmr_tick;

  // Command bits for SCLK period k: start, SGL/DIFF, D2..D0, then zeros.
  function automatic logic frame_mosi(input logic [4:0] k, input logic sgl,
                                      input logic [2:0] ch);
    case (k)
      5'd1:    return 1'b1;
      5'd2:    return sgl;
      5'd3:    return ch[2];
      5'd4:    return ch[1];
      5'd5:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

  spi_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (tmr_en),
    .clr_i (tmr_clr),
    .rise_o(tmr_rise),
    .fall_o(tmr_fall),
    .tick_o(tmr_tick)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sgl_d     = sgl_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    accel_d   = accel_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    tmr_en    = (state_q != StIdle);
    tmr_clr   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ch_d      = channel;
          sgl_d     = sgl_diff;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          mosi_d    = 1'b1;
          bit_cnt_d = 5'd1;
          shift_d   = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        // Restart the timer so the first SHIFT period begins with a full low phase.
        if (tmr_tick) begin
          tmr_clr = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (tmr_rise) begin
          sclk_d = 1'b1;
          if (bit_cnt_q >= FirstDataClk) begin
            shift_d = {shift_q[ADC_BITS-2:0], miso};
          end
        end else if (tmr_fall) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == LastClk) begin
            tmr_clr  = 1'b1;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            sample_d = shift_q;
            accel_d  = accel_scale(shift_q, LOW_TH, HIGH_TH, GAIN, ACCEL_MAX);
            valid_d  = 1'b1;
            state_d  = StHold;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            mosi_d    = frame_mosi(bit_cnt_q + 5'd1, sgl_q, ch_q);
          end
        end
      end
      StHold: begin
        if (tmr_tick) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      sgl_q     <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      accel_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sgl_q     <= sgl_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      accel_q   <= accel_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample       = sample_q;
  assign accel        = accel_q;
  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;

endmodule

// File: tb/tb_mcp3008_accel_reader.sv
// Bench for mcp3008_accel_reader: behavioural MCP3008 model, scoreboard of expected
// codes/scaling/command bits, and a second GAIN=1 instance run in lockstep.
module tb_mcp3008_accel_reader;

  localparam int unsigned CLK_DIV      = 2;
  localparam int          FRAME_BUDGET = 40 * CLK_DIV + 20;

  typedef struct packed {
    logic [9:0] code;
    logic [9:0] accel;
    logic [4:0] mosi5;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, sgl_diff;
  logic [2:0] channel;
  logic       miso = 1'b0;
  logic       busy, sample_valid, sclk, cs_n, mosi;
  logic [9:0] sample, accel;
  logic       busy_g1, valid_g1, sclk_g1, cs_n_g1, mosi_g1;
  logic [9:0] sample_g1, accel_g1;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [9:0] adc_code;
  logic [9:0] frame_code = '0;
  int         rise_cnt = 0;
  logic       mosi_cap [1:17];
  logic       cs_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  always #5 clk = ~clk;

  mcp3008_accel_reader #(
    .CLK_DIV(CLK_DIV), .LOW_TH(280), .HIGH_TH(780), .GAIN(2), .ACCEL_MAX(1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .channel(channel), .sgl_diff(sgl_diff),
    .busy(busy), .sample_valid(sample_valid), .sample(sample), .accel(accel),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  mcp3008_accel_reader #(
    .CLK_DIV(CLK_DIV), .LOW_TH(280), .HIGH_TH(780), .GAIN(1), .ACCEL_MAX(1000)
  ) dut_g1 (
    .clk(clk), .rst(rst), .start(start), .channel(channel), .sgl_diff(sgl_diff),
    .busy(busy_g1), .sample_valid(valid_g1), .sample(sample_g1), .accel(accel_g1),
    .sclk(sclk_g1), .cs_n(cs_n_g1), .mosi(mosi_g1), .miso(miso)
  );

  // MCP3008 model: records DIN on rising SCLK, shifts DOUT on falling SCLK so that
  // B9 is valid for the 8th rising edge and B0 for the 17th.
  always @(cs_n or sclk) begin
    if (cs_prev === 1'b1 && cs_n === 1'b0) begin
      rise_cnt   = 0;
      frame_code = adc_code;
      miso       = 1'b0;
    end
    if (sclk_prev === 1'b0 && sclk === 1'b1 && cs_n === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt <= 17) mosi_cap[rise_cnt] = mosi;
    end
    if (sclk_prev === 1'b1 && sclk === 1'b0) begin
      if (rise_cnt + 1 >= 8 && rise_cnt + 1 <= 17) miso = frame_code[17 - (rise_cnt + 1)];
      else miso = 1'b0;
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  function automatic int exp_accel(input int r, input int gain);
    int p;
    if (r < 280) return 0;
    if (r > 780) return 1000;
    p = (r - 280) * gain;
    return (p > 1000) ? 1000 : p;
  endfunction

  function automatic logic [4:0] got_mosi5();
    return {mosi_cap[1], mosi_cap[2], mosi_cap[3], mosi_cap[4], mosi_cap[5]};
  endfunction

  task automatic drive_start(input logic [9:0] code, input logic [2:0] ch, input logic sgl);
    exp_t e;
    @(negedge clk);
    adc_code = code;
    channel  = ch;
    sgl_diff = sgl;
    start    = 1'b1;
    e.code   = code;
    e.accel  = 10'(exp_accel(int'(code), 2));
    e.mosi5  = {1'b1, sgl, ch};
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 1; i <= FRAME_BUDGET; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sample_valid === 1'b1) begin
        lat = i;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", sample_valid);
    end
    checks++; if (sample !== 10'd0) begin errors++; $display("FAIL reset_sample: got %0d want 0", sample); end
    checks++; if (accel !== 10'd0) begin errors++; $display("FAIL reset_accel: got %0d want 0", accel); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat;
    bit to;
    exp_t e;
    drive_start(10'h2A5, 3'd0, 1'b1);
    wait_valid(lat, to);
    e = sb_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL single_timeout: no sample_valid"); end
    checks++;
    if (lat != 1 + 35 * CLK_DIV) begin
      errors++; $display("FAIL single_latency: got %0d want %0d", lat, 1 + 35 * CLK_DIV);
    end
    checks++; if (sample !== e.code) begin errors++; $display("FAIL single_sample: got %0d want %0d", sample, e.code); end
    checks++; if (accel !== e.accel) begin errors++; $display("FAIL single_accel: got %0d want %0d", accel, e.accel); end
    checks++;
    if (got_mosi5() !== e.mosi5) begin
      errors++; $display("FAIL single_mosi: got %b want %b", got_mosi5(), e.mosi5);
    end
    for (int i = 1; i <= CLK_DIV; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: valid held %b", sample_valid); end
      end
      if (i == CLK_DIV - 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b want 1", busy); end
      end
      if (i == CLK_DIV) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_thresholds;
    int codes [6] = '{279, 280, 780, 781, 1023, 0};
    int want2 [6] = '{0, 0, 1000, 1000, 1000, 0};
    int want1 [6] = '{0, 0, 500, 1000, 1000, 0};
    int lat;
    bit to;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      wait_idle(to);
      drive_start(10'(codes[i]), 3'(i), 1'b1);
      wait_valid(lat, to);
      e = sb_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL thr_timeout: code %0d", codes[i]); end
      checks++;
      if (sample !== e.code) begin errors++; $display("FAIL thr_sample: got %0d want %0d", sample, e.code); end
      checks++;
      if (accel !== 10'(want2[i])) begin
        errors++; $display("FAIL thr_accel: code %0d got %0d want %0d", codes[i], accel, want2[i]);
      end
      checks++;
      if (accel_g1 !== 10'(want1[i])) begin
        errors++; $display("FAIL thr_gain1: code %0d got %0d want %0d", codes[i], accel_g1, want1[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pushed = 0, valids = 0, win_valids = 0, hi_run = 0;
    logic prev_busy, prev_cs;
    bit to;
    exp_t e;
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL b2b_idle: busy never fell"); end
    adc_code  = 10'd500;
    prev_busy = busy;
    prev_cs   = cs_n;
    for (int cyc = 0; cyc < 4 * FRAME_BUDGET && valids < 3; cyc++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        valids++;
        win_valids++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected sample_valid");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (sample !== e.code) begin errors++; $display("FAIL b2b_sample: got %0d want %0d", sample, e.code); end
          checks++;
          if (accel !== e.accel) begin errors++; $display("FAIL b2b_accel: got %0d want %0d", accel, e.accel); end
          checks++;
          if (got_mosi5() !== e.mosi5) begin
            errors++; $display("FAIL b2b_mosi: got %b want %b", got_mosi5(), e.mosi5);
          end
        end
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        checks++;
        if (win_valids != 1) begin errors++; $display("FAIL b2b_window: %0d valids want 1", win_valids); end
        win_valids = 0;
      end
      if (prev_cs === 1'b1 && cs_n === 1'b0 && valids > 0) begin
        checks++;
        if (hi_run < CLK_DIV) begin errors++; $display("FAIL b2b_cs_gap: %0d cycles want >=%0d", hi_run, CLK_DIV); end
      end
      hi_run    = (cs_n === 1'b1) ? hi_run + 1 : 0;
      prev_busy = busy;
      prev_cs   = cs_n;
      if (busy === 1'b0 && pushed < 3) begin
        channel  = 3'($urandom_range(0, 7));
        sgl_diff = 1'($urandom_range(0, 1));
        start    = 1'b1;
        e.code   = adc_code;
        e.accel  = 10'(exp_accel(int'(adc_code), 2));
        e.mosi5  = {1'b1, sgl_diff, channel};
        sb_q.push_back(e);
        pushed++;
      end else if (busy === 1'b0) begin
        start = 1'b0;
      end else begin
        channel  = 3'($urandom_range(0, 7));
        sgl_diff = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    checks++; if (valids != 3) begin errors++; $display("FAIL b2b_count: %0d frames want 3", valids); end
  endtask

  task automatic test_reset_mid_frame;
    bit to, reached;
    int vcount, lat;
    exp_t e;
    wait_idle(to);
    drive_start(10'd600, 3'd2, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk === 1'b1 && rise_cnt == 10) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_reach_k10: never reached SCLK 10"); end
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b want 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (sample !== 10'd0) begin errors++; $display("FAIL rst_mid_sample: got %0d want 0", sample); end
    checks++; if (accel !== 10'd0) begin errors++; $display("FAIL rst_mid_accel: got %0d want 0", accel); end
    rst    = 1'b0;
    vcount = 0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL rst_mid_valid: %0d pulses want 0", vcount); end
    drive_start(10'd333, 3'd4, 1'b1);
    wait_valid(lat, to);
    e = sb_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL rst_after_timeout: no sample_valid"); end
    checks++; if (sample !== e.code) begin errors++; $display("FAIL rst_after_sample: got %0d want %0d", sample, e.code); end
    checks++; if (accel !== e.accel) begin errors++; $display("FAIL rst_after_accel: got %0d want %0d", accel, e.accel); end
    checks++;
    if (got_mosi5() !== e.mosi5) begin
      errors++; $display("FAIL rst_after_mosi: got %b want %b", got_mosi5(), e.mosi5);
    end
  endtask

  task automatic test_diff_ch5;
    int lat;
    bit to;
    exp_t e;
    wait_idle(to);
    drive_start(10'h3FF, 3'd5, 1'b0);
    wait_valid(lat, to);
    e = sb_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL diff_timeout: no sample_valid"); end
    checks++; if (sample !== 10'd1023) begin errors++; $display("FAIL diff_sample: got %0d want 1023", sample); end
    checks++; if (accel !== 10'd1000) begin errors++; $display("FAIL diff_accel: got %0d want 1000", accel); end
    checks++;
    if (got_mosi5() !== e.mosi5) begin
      errors++; $display("FAIL diff_mosi: got %b want %b", got_mosi5(), e.mosi5);
    end
  endtask

  task automatic test_protocol;
    bit to, done, seen_fall;
    int run_len;
    logic prev_sclk, prev_cs, prev_mosi;
    exp_t e;
    for (int f = 0; f < 20; f++) begin
      wait_idle(to);
      drive_start(10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      prev_sclk = sclk;
      prev_cs   = cs_n;
      prev_mosi = mosi;
      seen_fall = 1'b0;
      run_len   = 1;
      done      = 1'b0;
      for (int i = 0; i < FRAME_BUDGET && !done; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (cs_n !== prev_cs) begin
          checks++;
          if (sclk !== 1'b0) begin errors++; $display("FAIL proto_cs_sclk: cs_n toggled with sclk=%b", sclk); end
        end
        checks++;
        if (mosi !== prev_mosi && sclk === 1'b1) begin
          errors++; $display("FAIL proto_mosi: mosi changed %b->%b while sclk high", prev_mosi, mosi);
        end
        if (sclk !== prev_sclk) begin
          if (prev_sclk === 1'b1 || seen_fall) begin
            checks++;
            if (run_len != CLK_DIV) begin
              errors++; $display("FAIL proto_phase: sclk=%b lasted %0d want %0d", prev_sclk, run_len, CLK_DIV);
            end
          end
          if (prev_sclk === 1'b1) seen_fall = 1'b1;
          run_len = 1;
        end else begin
          run_len++;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        prev_mosi = mosi;
        if (sample_valid === 1'b1) done = 1'b1;
      end
      e = sb_q.pop_front();
      checks++; if (!done) begin errors++; $display("FAIL proto_timeout: frame %0d", f); end
      checks++; if (sample !== e.code) begin errors++; $display("FAIL proto_sample: got %0d want %0d", sample, e.code); end
      checks++; if (accel !== e.accel) begin errors++; $display("FAIL proto_accel: got %0d want %0d", accel, e.accel); end
      checks++;
      if (got_mosi5() !== e.mosi5) begin
        errors++; $display("FAIL proto_mosi_bits: got %b want %b", got_mosi5(), e.mosi5);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    channel  = 3'd0;
    sgl_diff = 1'b1;
    adc_code = 10'd0;
    test_reset;
    test_single;
    test_thresholds;
    test_back_to_back;
    test_reset_mid_frame;
    test_diff_ch5;
    test_protocol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
